// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback arbiter.
//   ADDRESS_WIDTH / DATA_WIDTH : default register index / data widths
//   reg_addr_t / reg_data_t    : register index and data types
//   wb_req_t                   : one writeback request {rd, wd}
//   wb_port_e                  : identifies writeback port A (ALU) or B (load unit)
package regfile_pkg;

  localparam int unsigned ADDRESS_WIDTH = 5;
  localparam int unsigned DATA_WIDTH    = 32;

  typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]    reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t wd;
  } wb_req_t;

  typedef enum logic [0:0] {
    PortA = 1'b0,
    PortB = 1'b1
  } wb_port_e;

endpackage

// File: rtl/regfile_wr_arb_if.sv
// Writeback request bundle for the two producers (A = ALU, B = load unit).
//   a_valid/a_ready/a_rd/a_wd : port A handshake and payload
//   b_valid/b_ready/b_rd/b_wd : port B handshake and payload
// Modports: master = request producer side, slave = arbiter side.
interface regfile_wr_arb_if #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) ();

  logic                     a_valid;
  logic                     a_ready;
  logic [ADDRESS_WIDTH-1:0] a_rd;
  logic [DATA_WIDTH-1:0]    a_wd;
  logic                     b_valid;
  logic                     b_ready;
  logic [ADDRESS_WIDTH-1:0] b_rd;
  logic [DATA_WIDTH-1:0]    b_wd;

  modport master (
    output a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_wd, b_valid, b_rd, b_wd,
    output a_ready, b_ready
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-request arbiter for the writeback port.
//   clk    : clock
//   rst    : synchronous active-high reset; forces grants low
//   req_i  : {B, A} requests
//   gnt_o  : {B, A} one-hot grant (combinational)
// Policy: with WB_ARB_RR_EN defined the grant alternates (a pointer names the
// preferred port and moves to the other port after every grant); otherwise A
// has fixed priority and no state exists.
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef WB_ARB_RR_EN
  wb_port_e ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (!rst) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (ptr_q == PortA) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      // Every grant hands preference to the other port, even an uncontested one.
      if (gnt_o[0]) begin
        ptr_d = PortB;
      end else if (gnt_o[1]) begin
        ptr_d = PortA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PortA;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority is purely combinational; the clock is not needed.
  logic unused_clk;
  assign unused_clk = clk;

  always_comb begin
    gnt_o = 2'b00;
    if (!rst) begin
      if (req_i[0]) begin
        gnt_o = 2'b01;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file writeback arbiter with scoreboard.
// Merges ALU (A) and load-unit (B) writebacks onto one register-file write
// port and tracks which registers have an issued-but-unwritten result.
//   clk, rst            : clock, synchronous active-high reset
//   wb (slave)          : A/B writeback requests, ready is combinational
//   iss_valid, iss_rd   : issued instruction that will write iss_rd
//   rs1/rs2, rsN_busy   : decode hazard query (combinational)
//   we3, ad3, wd3       : registered register-file write port
// Arbitration policy: WB_ARB_RR_EN selects round-robin, default fixed A-first.
module regfile_wr_arb #(
  parameter int unsigned ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = regfile_pkg::DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_wr_arb_if.slave          wb,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3
);

  localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;

  logic [1:0]               gnt;
  logic                     xfer;
  logic [ADDRESS_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0]    sel_wd;

  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
  logic [NumRegs-1:0]       pending_q, pending_d;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({wb.b_valid, wb.a_valid}),
    .gnt_o (gnt)
  );

  assign wb.a_ready = gnt[0];
  assign wb.b_ready = gnt[1];

  // Grants are only raised for valid ports, so a grant is a transfer.
  assign xfer   = |gnt;
  assign sel_rd = gnt[1] ? wb.b_rd : wb.a_rd;
  assign sel_wd = gnt[1] ? wb.b_wd : wb.a_wd;

  always_comb begin
    we3_d = 1'b0;
    ad3_d = ad3_q;
    wd3_d = wd3_q;
    if (xfer) begin
      // Writes to x0 are accepted but never reach the register file.
      we3_d = (sel_rd != '0);
      ad3_d = sel_rd;
      wd3_d = sel_wd;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (we3_q) begin
      pending_d[ad3_q] = 1'b0;
    end
    // Applied after the clear so a same-edge issue to the written register wins.
    if (iss_valid && (iss_rd != '0)) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3_q     <= 1'b0;
      ad3_q     <= '0;
      wd3_q     <= '0;
      pending_q <= '0;
    end else begin
      we3_q     <= we3_d;
      ad3_q     <= ad3_d;
      wd3_q     <= wd3_d;
      pending_q <= pending_d;
    end
  end

  assign we3 = we3_q;
  assign ad3 = ad3_q;
  assign wd3 = wd3_q;

  assign rs1_busy = (rs1 != '0) && pending_q[rs1];
  assign rs2_busy = (rs2 != '0) && pending_q[rs2];

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: a table of directed cycles for the listed corner
// cases, then randomized traffic checked against a behavioural model.
// Build with or without WB_ARB_RR_EN; expectations follow the macro.
module tb_regfile_wr_arb;
  import regfile_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
`ifdef WB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic [AW-1:0] iss_rd, rs1, rs2;
  logic          rs1_busy, rs2_busy, we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;

  regfile_wr_arb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  regfile_wr_arb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .we3       (we3),
    .ad3       (ad3),
    .wd3       (wd3)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit av, input int unsigned ard, input int unsigned awd,
                       input bit bv, input int unsigned brd, input int unsigned bwd,
                       input bit iv, input int unsigned ird,
                       input int unsigned r1, input int unsigned r2);
    rst        = r;
    wb.a_valid = av;
    wb.a_rd    = AW'(ard);
    wb.a_wd    = DW'(awd);
    wb.b_valid = bv;
    wb.b_rd    = AW'(brd);
    wb.b_wd    = DW'(bwd);
    iss_valid  = iv;
    iss_rd     = AW'(ird);
    rs1        = AW'(r1);
    rs2        = AW'(r2);
  endtask

  // One row = one clock cycle: inputs, then outputs expected during that cycle.
  typedef struct {
    bit          rst;
    bit          av;  int unsigned ard; int unsigned awd;
    bit          bv;  int unsigned brd; int unsigned bwd;
    bit          iv;  int unsigned ird;
    int unsigned r1;  int unsigned r2;
    bit          ea;  bit eb; bit e1; bit e2;
    bit          ewe; bit chk_wb; int unsigned ead; int unsigned ewd;
  } vec_t;

  localparam int NumVec = 22;
  vec_t tbl [NumVec];

  // Behavioural model state for the random phase.
  bit [31:0]   m_pend;
  bit          m_pref_b;
  bit          m_we;
  int unsigned m_ad, m_wd;

  initial begin
    bit          r, av, bv, iv, ga, gb;
    int unsigned ard, awd, brd, bwd, ird, r1, r2;

    // rst av ard awd  bv brd bwd  iv ird  r1 r2  ea eb e1 e2  we chk ad wd
    tbl[0]  = '{1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 32'hDEADBEEF};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF};
    tbl[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF};
    tbl[5]  = '{0, 1, 1, 'h11, 1, 2, 'h22, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 1, 'h11, 1, 2, 'h22, 0, 0, 0, 0, !RR, RR, 0, 0, 1, 1, 1, 'h11};
    tbl[7]  = '{0, 1, 1, 'h11, 1, 2, 'h22, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1,
                RR ? 2 : 1, RR ? 'h22 : 'h11};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 1, 1, 1, 'h11};
    tbl[9]  = '{0, 0, 0, 0, 1, 7, 'h77, 0, 0, 7, 0, 0, 1, 1, 0, 0, 1, 1, 'h11};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 1, 1, 7, 'h77};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 7, 'h77};
    tbl[12] = '{0, 1, 9, 'h99, 0, 0, 0, 1, 9, 0, 9, 1, 0, 0, 0, 0, 1, 7, 'h77};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 9, 0, 0, 0, 1, 1, 1, 9, 'h99};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 0, 1, 9, 'h99};
    tbl[15] = '{0, 1, 0, 'h1234, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 1, 9, 'h99};
    tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 3, 'h33, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 0};
    tbl[18] = '{1, 1, 4, 'h44, 1, 5, 'h55, 0, 0, 3, 9, 0, 0, 0, 1, 1, 1, 3, 'h33};
    tbl[19] = '{1, 1, 4, 'h44, 1, 5, 'h55, 0, 0, 3, 9, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[20] = '{0, 1, 4, 'h44, 1, 5, 'h55, 0, 0, 3, 9, 1, 0, 0, 0, 0, 1, 0, 0};
    tbl[21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 'h44};

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < NumVec; i++) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ard, tbl[i].awd, tbl[i].bv, tbl[i].brd,
            tbl[i].bwd, tbl[i].iv, tbl[i].ird, tbl[i].r1, tbl[i].r2);
      #1;
      check_bit($sformatf("row%0d a_ready", i), wb.a_ready, tbl[i].ea);
      check_bit($sformatf("row%0d b_ready", i), wb.b_ready, tbl[i].eb);
      check_bit($sformatf("row%0d rs1_busy", i), rs1_busy, tbl[i].e1);
      check_bit($sformatf("row%0d rs2_busy", i), rs2_busy, tbl[i].e2);
      check_bit($sformatf("row%0d we3", i), we3, tbl[i].ewe);
      if (tbl[i].chk_wb) begin
        check_val($sformatf("row%0d ad3", i), 32'(ad3), tbl[i].ead);
        check_val($sformatf("row%0d wd3", i), 32'(wd3), tbl[i].ewd);
      end
      @(posedge clk);
      #1;
    end

    // Random traffic; small index range so issues, writes and queries collide.
    m_pend = '0; m_pref_b = 1'b0; m_we = 1'b0; m_ad = 0; m_wd = 0;
    for (int c = 0; c < 500; c++) begin
      r   = (c < 2) || ($urandom_range(0, 39) == 0);
      av  = ($urandom_range(0, 1) == 1);
      bv  = ($urandom_range(0, 1) == 1);
      iv  = ($urandom_range(0, 2) == 0);
      ard = $urandom_range(0, 7);
      brd = $urandom_range(0, 7);
      ird = $urandom_range(0, 7);
      r1  = $urandom_range(0, 7);
      r2  = $urandom_range(0, 7);
      awd = $urandom;
      bwd = $urandom;
      drive(r, av, ard, awd, bv, brd, bwd, iv, ird, r1, r2);
      #1;

      ga = 1'b0;
      gb = 1'b0;
      if (!r) begin
        if (av && bv) begin
          if (RR && m_pref_b) gb = 1'b1;
          else                ga = 1'b1;
        end else begin
          ga = av;
          gb = bv;
        end
      end

      // Model state is unknown until the first reset cycle has been applied.
      if (c > 0) begin
        check_bit($sformatf("rnd%0d a_ready", c), wb.a_ready, ga);
        check_bit($sformatf("rnd%0d b_ready", c), wb.b_ready, gb);
        check_bit($sformatf("rnd%0d rs1_busy", c), rs1_busy, (r1 != 0) && m_pend[r1]);
        check_bit($sformatf("rnd%0d rs2_busy", c), rs2_busy, (r2 != 0) && m_pend[r2]);
        check_bit($sformatf("rnd%0d we3", c), we3, m_we);
        check_val($sformatf("rnd%0d ad3", c), 32'(ad3), m_ad);
        check_val($sformatf("rnd%0d wd3", c), 32'(wd3), m_wd);
      end

      if (r) begin
        m_pend = '0; m_pref_b = 1'b0; m_we = 1'b0; m_ad = 0; m_wd = 0;
      end else begin
        if (m_we) m_pend[m_ad] = 1'b0;
        if (iv && ird != 0) m_pend[ird] = 1'b1;
        if (ga) begin
          m_we = (ard != 0); m_ad = ard; m_wd = awd; m_pref_b = 1'b1;
        end else if (gb) begin
          m_we = (brd != 0); m_ad = brd; m_wd = bwd; m_pref_b = 1'b0;
        end else begin
          m_we = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
